// File: rtl/m_trap_unit.sv
// m_trap_unit: machine-mode CSR file and trap sequencer for the Lagarto Hun core.
// Serves CSR read/write/set/clear accesses, takes exceptions and the three
// machine interrupts, executes mret and drives a PC-redirect handshake to fetch.
// Optional feature macro: LAGARTO_MTVEC_VECTORED_EN enables vectored mtvec mode.
module m_trap_unit #(
    parameter int               MXLEN       = 64,
    parameter int               XLEN        = 64,
    parameter logic [MXLEN-1:0] HART_ID     = '0,
    parameter logic [MXLEN-1:0] RESET_MTVEC = '0
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic [11:0]      csr_address_i,
    input  logic [2:0]       csr_command_i,
    input  logic [MXLEN-1:0] csr_write_data_i,
    output logic [MXLEN-1:0] csr_read_data_o,
    output logic             csr_read_data_valid_o,
    output logic             csr_illegal_o,
    input  logic             exception_i,
    input  logic [4:0]       exception_cause_i,
    input  logic [XLEN-1:0]  exception_pc_i,
    input  logic [MXLEN-1:0] exception_tval_i,
    input  logic             mret_i,
    input  logic             irq_software_i,
    input  logic             irq_timer_i,
    input  logic             irq_external_i,
    input  logic [XLEN-1:0]  interrupt_pc_i,
    output logic             busy_o,
    output logic             redirect_valid_o,
    input  logic             redirect_ready_i,
    output logic [XLEN-1:0]  redirect_pc_o
);

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MISA     = 12'h301;
    localparam logic [11:0] ADDR_MIE      = 12'h304;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MTVAL    = 12'h343;
    localparam logic [11:0] ADDR_MIP      = 12'h344;
    localparam logic [11:0] ADDR_MHARTID  = 12'hF14;

    localparam logic [2:0] CMD_READ_ONLY   = 3'd1;
    localparam logic [2:0] CMD_WRITE_ONLY  = 3'd2;
    localparam logic [2:0] CMD_WRITE_READ  = 3'd3;
    localparam logic [2:0] CMD_SET_READ    = 3'd4;
    localparam logic [2:0] CMD_CLEAR_READ  = 3'd5;

    typedef enum logic {
        IDLE,
        REDIRECT
    } state_t;

    state_t state_q, state_d;

    logic             mie_bit_q;
    logic             mpie_bit_q;
    logic [MXLEN-1:0] mie_q;
    logic [MXLEN-1:0] mtvec_q;
    logic [MXLEN-1:0] mscratch_q;
    logic [MXLEN-1:0] mepc_q;
    logic [MXLEN-1:0] mcause_q;
    logic [MXLEN-1:0] mtval_q;
    logic [2:0]       irq_q;
    logic [XLEN-1:0]  redirect_pc_q;

    logic [MXLEN-1:0] mstatus_val;
    logic [MXLEN-1:0] misa_val;
    logic [MXLEN-1:0] mip_val;
    logic [MXLEN-1:0] irq_enabled;
    logic             irq_pending;
    logic [4:0]       irq_code;

    logic [MXLEN-1:0] csr_old;
    logic             csr_exists;
    logic             cmd_is_access;
    logic             cmd_is_write;
    logic             access_illegal;
    logic [MXLEN-1:0] csr_wval;
    logic             csr_slot;
    logic             csr_commit;

    logic             idle;
    logic             take_exc;
    logic             take_irq;
    logic             take_mret;

    logic [XLEN-1:0]  trap_pc;
    logic [MXLEN-1:0] trap_pc_wide;
    logic [MXLEN-1:0] trap_epc;
    logic [MXLEN-1:0] trap_cause;
    logic [XLEN-1:0]  mtvec_base;
    logic [XLEN-1:0]  trap_target;

    // Architectural views of the composite and read-only registers
    always_comb begin
        mstatus_val        = '0;
        mstatus_val[3]     = mie_bit_q;
        mstatus_val[7]     = mpie_bit_q;
        mstatus_val[12:11] = 2'b11;
        misa_val           = '0;
        misa_val[MXLEN-1:MXLEN-2] = (MXLEN == 32) ? 2'b01 : 2'b10;
        misa_val[8]        = 1'b1;
        mip_val            = '0;
        mip_val[3]         = irq_q[0];
        mip_val[7]         = irq_q[1];
        mip_val[11]        = irq_q[2];
    end

    // Interrupt arbitration: external beats software, software beats timer
    always_comb begin
        irq_enabled = mip_val & mie_q;
        irq_pending = mie_bit_q & (|irq_enabled);
        if (irq_enabled[11]) begin
            irq_code = 5'd11;
        end else if (irq_enabled[3]) begin
            irq_code = 5'd3;
        end else begin
            irq_code = 5'd7;
        end
    end

    // CSR address decode and old-value mux
    always_comb begin
        csr_old    = '0;
        csr_exists = 1'b1;
        case (csr_address_i)
            ADDR_MSTATUS:  csr_old = mstatus_val;
            ADDR_MISA:     csr_old = misa_val;
            ADDR_MIE:      csr_old = mie_q;
            ADDR_MTVEC:    csr_old = mtvec_q;
            ADDR_MSCRATCH: csr_old = mscratch_q;
            ADDR_MEPC:     csr_old = mepc_q;
            ADDR_MCAUSE:   csr_old = mcause_q;
            ADDR_MTVAL:    csr_old = mtval_q;
            ADDR_MIP:      csr_old = mip_val;
            ADDR_MHARTID:  csr_old = HART_ID;
            default:       csr_exists = 1'b0;
        endcase
    end

    // Command classification, legality and read-modify-write value
    always_comb begin
        cmd_is_access  = (csr_command_i >= CMD_READ_ONLY) && (csr_command_i <= CMD_CLEAR_READ);
        cmd_is_write   = (csr_command_i >= CMD_WRITE_ONLY) && (csr_command_i <= CMD_CLEAR_READ);
        access_illegal = !csr_exists
                       || (cmd_is_write && (csr_address_i[11:10] == 2'b11))
                       || (cmd_is_write && (csr_address_i == ADDR_MISA));
        case (csr_command_i)
            CMD_SET_READ:   csr_wval = csr_old | csr_write_data_i;
            CMD_CLEAR_READ: csr_wval = csr_old & ~csr_write_data_i;
            default:        csr_wval = csr_write_data_i;
        endcase
    end

    // Event priority in IDLE: exception, interrupt, mret, then the CSR command
    assign idle      = (state_q == IDLE);
    assign take_exc  = idle && exception_i;
    assign take_irq  = idle && !exception_i && irq_pending;
    assign take_mret = idle && !exception_i && !irq_pending && mret_i;
    assign csr_slot  = idle && !exception_i && !irq_pending && !mret_i;

    assign csr_read_data_valid_o = csr_slot && cmd_is_access && !access_illegal;
    assign csr_illegal_o         = csr_slot && cmd_is_access && access_illegal;
    assign csr_read_data_o       = csr_read_data_valid_o ? csr_old : '0;
    assign csr_commit            = csr_read_data_valid_o && cmd_is_write;

    // Trap bookkeeping values and the fetch target for a new trap
    always_comb begin
        trap_pc            = take_exc ? exception_pc_i : interrupt_pc_i;
        trap_pc_wide       = MXLEN'(trap_pc);
        trap_epc           = {trap_pc_wide[MXLEN-1:2], 2'b00};
        trap_cause         = '0;
        trap_cause[MXLEN-1] = !take_exc;
        trap_cause[4:0]    = take_exc ? exception_cause_i : irq_code;
        mtvec_base         = XLEN'({mtvec_q[MXLEN-1:2], 2'b00});
`ifdef LAGARTO_MTVEC_VECTORED_EN
        if (!take_exc && mtvec_q[0]) begin
            trap_target = mtvec_base + (XLEN'(irq_code) << 2);
        end else begin
            trap_target = mtvec_base;
        end
`else
        trap_target        = mtvec_base;
`endif
    end

    // Sequencer state register
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake outputs; the redirect drops on the accepting edge
    always_comb begin
        state_d          = state_q;
        busy_o           = 1'b0;
        redirect_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (take_exc || take_irq || take_mret) begin
                    state_d = REDIRECT;
                end
            end
            REDIRECT: begin
                busy_o           = 1'b1;
                redirect_valid_o = 1'b1;
                if (redirect_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign redirect_pc_o = redirect_pc_q;

    // CSR storage: trap entry, mret and CSR writes, each with its write mask
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            mie_bit_q     <= 1'b0;
            mpie_bit_q    <= 1'b0;
            mie_q         <= '0;
            mtvec_q       <= RESET_MTVEC;
            mscratch_q    <= '0;
            mepc_q        <= '0;
            mcause_q      <= '0;
            mtval_q       <= '0;
            irq_q         <= '0;
            redirect_pc_q <= '0;
        end else begin
            irq_q <= {irq_external_i, irq_timer_i, irq_software_i};
            if (take_exc || take_irq) begin
                mepc_q        <= trap_epc;
                mcause_q      <= trap_cause;
                mtval_q       <= take_exc ? exception_tval_i : '0;
                mpie_bit_q    <= mie_bit_q;
                mie_bit_q     <= 1'b0;
                redirect_pc_q <= trap_target;
            end else if (take_mret) begin
                mie_bit_q     <= mpie_bit_q;
                mpie_bit_q    <= 1'b1;
                redirect_pc_q <= XLEN'(mepc_q);
            end else if (csr_commit) begin
                case (csr_address_i)
                    ADDR_MSTATUS: begin
                        mie_bit_q  <= csr_wval[3];
                        mpie_bit_q <= csr_wval[7];
                    end
                    ADDR_MIE: begin
                        mie_q     <= '0;
                        mie_q[3]  <= csr_wval[3];
                        mie_q[7]  <= csr_wval[7];
                        mie_q[11] <= csr_wval[11];
                    end
                    ADDR_MTVEC: begin
`ifdef LAGARTO_MTVEC_VECTORED_EN
                        mtvec_q <= {csr_wval[MXLEN-1:2], (csr_wval[1] ? 2'b00 : csr_wval[1:0])};
`else
                        mtvec_q <= {csr_wval[MXLEN-1:2], 2'b00};
`endif
                    end
                    ADDR_MSCRATCH: mscratch_q <= csr_wval;
                    ADDR_MEPC:     mepc_q     <= {csr_wval[MXLEN-1:2], 2'b00};
                    ADDR_MCAUSE:   mcause_q   <= csr_wval;
                    ADDR_MTVAL:    mtval_q    <= csr_wval;
                    default:       ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_m_trap_unit.sv
// tb_m_trap_unit: directed self-checking bench for m_trap_unit (MXLEN=XLEN=64).
// Expected vectored-mode targets follow LAGARTO_MTVEC_VECTORED_EN when defined.
module tb_m_trap_unit;

    localparam logic [63:0] T_HART_ID     = 64'h3;
    localparam logic [63:0] T_RESET_MTVEC = 64'h400;

    logic        clock;
    logic        reset;
    logic [11:0] csr_address;
    logic [2:0]  csr_command;
    logic [63:0] csr_write_data;
    logic [63:0] csr_read_data;
    logic        csr_read_data_valid;
    logic        csr_illegal;
    logic        exception;
    logic [4:0]  exception_cause;
    logic [63:0] exception_pc;
    logic [63:0] exception_tval;
    logic        mret;
    logic        irq_software;
    logic        irq_timer;
    logic        irq_external;
    logic [63:0] interrupt_pc;
    logic        busy;
    logic        redirect_valid;
    logic        redirect_ready;
    logic [63:0] redirect_pc;

    int n_checks;
    int n_pass;

    logic [63:0] rd;
    logic        vld;
    logic        ill;
    logic [63:0] exp_val;

    m_trap_unit #(
        .MXLEN(64),
        .XLEN(64),
        .HART_ID(T_HART_ID),
        .RESET_MTVEC(T_RESET_MTVEC)
    ) dut (
        .clock_i(clock),
        .reset_i(reset),
        .csr_address_i(csr_address),
        .csr_command_i(csr_command),
        .csr_write_data_i(csr_write_data),
        .csr_read_data_o(csr_read_data),
        .csr_read_data_valid_o(csr_read_data_valid),
        .csr_illegal_o(csr_illegal),
        .exception_i(exception),
        .exception_cause_i(exception_cause),
        .exception_pc_i(exception_pc),
        .exception_tval_i(exception_tval),
        .mret_i(mret),
        .irq_software_i(irq_software),
        .irq_timer_i(irq_timer),
        .irq_external_i(irq_external),
        .interrupt_pc_i(interrupt_pc),
        .busy_o(busy),
        .redirect_valid_o(redirect_valid),
        .redirect_ready_i(redirect_ready),
        .redirect_pc_o(redirect_pc)
    );

    // Free-running clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Guard against a hung run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present one CSR command, capture the combinational response, then commit it
    task automatic csr_access(input logic [2:0] cmd, input logic [11:0] addr, input logic [63:0] wdata,
                              output logic [63:0] rdata, output logic valid, output logic illegal);
        csr_command    = cmd;
        csr_address    = addr;
        csr_write_data = wdata;
        #1;
        rdata   = csr_read_data;
        valid   = csr_read_data_valid;
        illegal = csr_illegal;
        tick();
        csr_command    = 3'd0;
        csr_write_data = 64'h0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        n_checks++; if ({busy, redirect_valid} !== 2'b00) $display("[TB] FAIL reset_busy_valid got %b want 00", {busy, redirect_valid}); else n_pass++;
        n_checks++; if (redirect_pc !== 64'h0) $display("[TB] FAIL reset_redirect_pc got %h want 0", redirect_pc); else n_pass++;
        csr_access(3'd1, 12'h301, 64'h0, rd, vld, ill);
        n_checks++; if (rd !== 64'h8000_0000_0000_0100) $display("[TB] FAIL misa_read got %h want 8000000000000100", rd); else n_pass++;
        n_checks++; if (vld !== 1'b1) $display("[TB] FAIL misa_valid got %b want 1", vld); else n_pass++;
        csr_access(3'd1, 12'h305, 64'h0, rd, vld, ill);
        n_checks++; if (rd !== T_RESET_MTVEC) $display("[TB] FAIL mtvec_reset got %h want %h", rd, T_RESET_MTVEC); else n_pass++;
        csr_access(3'd1, 12'h300, 64'h0, rd, vld, ill);
        n_checks++; if (rd !== 64'h1800) $display("[TB] FAIL mstatus_reset got %h want 1800", rd); else n_pass++;
    endtask

    task automatic test_csr_rmw();
        csr_access(3'd2, 12'h340, 64'hF0, rd, vld, ill);
        csr_access(3'd1, 12'h340, 64'h0, rd, vld, ill);
        n_checks++; if (rd !== 64'hF0) $display("[TB] FAIL mscratch_write got %h want f0", rd); else n_pass++;
        csr_access(3'd4, 12'h340, 64'h0F, rd, vld, ill);
        n_checks++; if (rd !== 64'hF0) $display("[TB] FAIL set_old_value got %h want f0", rd); else n_pass++;
        csr_access(3'd1, 12'h340, 64'h0, rd, vld, ill);
        n_checks++; if (rd !== 64'hFF) $display("[TB] FAIL mscratch_set got %h want ff", rd); else n_pass++;
        csr_access(3'd5, 12'h340, 64'h30, rd, vld, ill);
        csr_access(3'd1, 12'h340, 64'h0, rd, vld, ill);
        n_checks++; if (rd !== 64'hCF) $display("[TB] FAIL mscratch_clear got %h want cf", rd); else n_pass++;
        csr_access(3'd2, 12'hF14, 64'h77, rd, vld, ill);
        n_checks++; if ({ill, vld} !== 2'b10) $display("[TB] FAIL mhartid_write_flags got %b want 10", {ill, vld}); else n_pass++;
        n_checks++; if (rd !== 64'h0) $display("[TB] FAIL illegal_rdata got %h want 0", rd); else n_pass++;
        csr_access(3'd1, 12'hF14, 64'h0, rd, vld, ill);
        n_checks++; if (rd !== T_HART_ID) $display("[TB] FAIL mhartid_read got %h want %h", rd, T_HART_ID); else n_pass++;
        csr_access(3'd3, 12'h301, 64'h0, rd, vld, ill);
        n_checks++; if ({ill, vld} !== 2'b10) $display("[TB] FAIL misa_write_flags got %b want 10", {ill, vld}); else n_pass++;
        csr_access(3'd1, 12'h7C0, 64'h0, rd, vld, ill);
        n_checks++; if ({ill, vld} !== 2'b10) $display("[TB] FAIL unimpl_read_flags got %b want 10", {ill, vld}); else n_pass++;
        csr_access(3'd2, 12'h341, 64'h1237, rd, vld, ill);
        csr_access(3'd1, 12'h341, 64'h0, rd, vld, ill);
        n_checks++; if (rd !== 64'h1234) $display("[TB] FAIL mepc_mask got %h want 1234", rd); else n_pass++;
        csr_access(3'd2, 12'h344, 64'hFFFF, rd, vld, ill);
        n_checks++; if ({ill, vld} !== 2'b01) $display("[TB] FAIL mip_write_flags got %b want 01", {ill, vld}); else n_pass++;
        csr_access(3'd1, 12'h344, 64'h0, rd, vld, ill);
        n_checks++; if (rd !== 64'h0) $display("[TB] FAIL mip_read got %h want 0", rd); else n_pass++;
    endtask

    task automatic test_exception();
        csr_access(3'd2, 12'h305, 64'h1000, rd, vld, ill);
        csr_access(3'd2, 12'h300, 64'h8, rd, vld, ill);
        exception       = 1'b1;
        exception_cause = 5'd2;
        exception_pc    = 64'h2002;
        exception_tval  = 64'hDEAD;
        tick();
        exception = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if ({busy, redirect_valid} !== 2'b11) $display("[TB] FAIL exc_hold_%0d_flags got %b want 11", i, {busy, redirect_valid}); else n_pass++;
            n_checks++; if (redirect_pc !== 64'h1000) $display("[TB] FAIL exc_hold_%0d_pc got %h want 1000", i, redirect_pc); else n_pass++;
            if (i < 2) tick();
        end
        csr_command = 3'd1;
        csr_address = 12'h340;
        #1;
        n_checks++; if (csr_read_data_valid !== 1'b0) $display("[TB] FAIL csr_in_redirect_valid got %b want 0", csr_read_data_valid); else n_pass++;
        csr_command    = 3'd0;
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
        n_checks++; if ({busy, redirect_valid} !== 2'b00) $display("[TB] FAIL exc_accept_flags got %b want 00", {busy, redirect_valid}); else n_pass++;
        csr_access(3'd1, 12'h341, 64'h0, rd, vld, ill);
        n_checks++; if (rd !== 64'h2000) $display("[TB] FAIL exc_mepc got %h want 2000", rd); else n_pass++;
        csr_access(3'd1, 12'h342, 64'h0, rd, vld, ill);
        n_checks++; if (rd !== 64'h2) $display("[TB] FAIL exc_mcause got %h want 2", rd); else n_pass++;
        csr_access(3'd1, 12'h343, 64'h0, rd, vld, ill);
        n_checks++; if (rd !== 64'hDEAD) $display("[TB] FAIL exc_mtval got %h want dead", rd); else n_pass++;
        csr_access(3'd1, 12'h300, 64'h0, rd, vld, ill);
        n_checks++; if (rd !== 64'h1880) $display("[TB] FAIL exc_mstatus got %h want 1880", rd); else n_pass++;
    endtask

    task automatic test_interrupt_mret();
        csr_access(3'd2, 12'h300, 64'h8, rd, vld, ill);
        csr_access(3'd2, 12'h304, 64'hFFFF_FFFF_FFFF_FFFF, rd, vld, ill);
        csr_access(3'd1, 12'h304, 64'h0, rd, vld, ill);
        n_checks++; if (rd !== 64'h888) $display("[TB] FAIL mie_mask got %h want 888", rd); else n_pass++;
        interrupt_pc = 64'h3006;
        irq_timer    = 1'b1;
        irq_external = 1'b1;
        tick();
        n_checks++; if (busy !== 1'b0) $display("[TB] FAIL irq_sync_delay got %b want 0", busy); else n_pass++;
        tick();
        n_checks++; if ({busy, redirect_valid} !== 2'b11) $display("[TB] FAIL irq_taken_flags got %b want 11", {busy, redirect_valid}); else n_pass++;
        n_checks++; if (redirect_pc !== 64'h1000) $display("[TB] FAIL irq_target got %h want 1000", redirect_pc); else n_pass++;
        irq_timer      = 1'b0;
        irq_external   = 1'b0;
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
        csr_access(3'd1, 12'h342, 64'h0, rd, vld, ill);
        n_checks++; if (rd !== 64'h8000_0000_0000_000B) $display("[TB] FAIL irq_mcause got %h want 800000000000000b", rd); else n_pass++;
        csr_access(3'd1, 12'h341, 64'h0, rd, vld, ill);
        n_checks++; if (rd !== 64'h3004) $display("[TB] FAIL irq_mepc got %h want 3004", rd); else n_pass++;
        csr_access(3'd1, 12'h343, 64'h0, rd, vld, ill);
        n_checks++; if (rd !== 64'h0) $display("[TB] FAIL irq_mtval got %h want 0", rd); else n_pass++;
        csr_access(3'd1, 12'h300, 64'h0, rd, vld, ill);
        n_checks++; if (rd !== 64'h1880) $display("[TB] FAIL irq_mstatus got %h want 1880", rd); else n_pass++;
        mret = 1'b1;
        tick();
        mret = 1'b0;
        n_checks++; if (busy !== 1'b1) $display("[TB] FAIL mret_busy got %b want 1", busy); else n_pass++;
        n_checks++; if (redirect_pc !== 64'h3004) $display("[TB] FAIL mret_target got %h want 3004", redirect_pc); else n_pass++;
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
        csr_access(3'd1, 12'h300, 64'h0, rd, vld, ill);
        n_checks++; if (rd !== 64'h1888) $display("[TB] FAIL mret_mstatus got %h want 1888", rd); else n_pass++;
    endtask

    task automatic test_vectored();
        csr_access(3'd2, 12'h305, 64'h1001, rd, vld, ill);
        csr_access(3'd1, 12'h305, 64'h0, rd, vld, ill);
`ifdef LAGARTO_MTVEC_VECTORED_EN
        exp_val = 64'h1001;
`else
        exp_val = 64'h1000;
`endif
        n_checks++; if (rd !== exp_val) $display("[TB] FAIL mtvec_mode_read got %h want %h", rd, exp_val); else n_pass++;
        irq_timer = 1'b1;
        tick();
        tick();
`ifdef LAGARTO_MTVEC_VECTORED_EN
        exp_val = 64'h101C;
`else
        exp_val = 64'h1000;
`endif
        n_checks++; if (redirect_pc !== exp_val) $display("[TB] FAIL timer_target got %h want %h", redirect_pc, exp_val); else n_pass++;
        irq_timer      = 1'b0;
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
        csr_access(3'd1, 12'h342, 64'h0, rd, vld, ill);
        n_checks++; if (rd !== 64'h8000_0000_0000_0007) $display("[TB] FAIL timer_mcause got %h want 8000000000000007", rd); else n_pass++;
    endtask

    task automatic test_back_to_back();
        exception       = 1'b1;
        exception_cause = 5'd5;
        exception_pc    = 64'h4000;
        exception_tval  = 64'h1;
        csr_access(3'd2, 12'h340, 64'h55, rd, vld, ill);
        exception = 1'b0;
        n_checks++; if ({vld, ill} !== 2'b00) $display("[TB] FAIL dropped_csr_flags got %b want 00", {vld, ill}); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("[TB] FAIL exc_over_csr_busy got %b want 1", busy); else n_pass++;
        n_checks++; if (redirect_pc !== 64'h1000) $display("[TB] FAIL exc_base_target got %h want 1000", redirect_pc); else n_pass++;
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
        csr_access(3'd1, 12'h340, 64'h0, rd, vld, ill);
        n_checks++; if (rd !== 64'hCF) $display("[TB] FAIL dropped_csr_value got %h want cf", rd); else n_pass++;
        csr_access(3'd1, 12'h342, 64'h0, rd, vld, ill);
        n_checks++; if (rd !== 64'h5) $display("[TB] FAIL b2b_mcause got %h want 5", rd); else n_pass++;
        exception = 1'b1;
        tick();
        exception = 1'b0;
        n_checks++; if (redirect_valid !== 1'b1) $display("[TB] FAIL pre_reset_valid got %b want 1", redirect_valid); else n_pass++;
        reset = 1'b1;
        tick();
        n_checks++; if ({busy, redirect_valid} !== 2'b00) $display("[TB] FAIL reset_redirect_flags got %b want 00", {busy, redirect_valid}); else n_pass++;
        n_checks++; if (redirect_pc !== 64'h0) $display("[TB] FAIL reset_redirect_pc got %h want 0", redirect_pc); else n_pass++;
        reset = 1'b0;
        csr_access(3'd1, 12'h305, 64'h0, rd, vld, ill);
        n_checks++; if (rd !== T_RESET_MTVEC) $display("[TB] FAIL mtvec_after_reset got %h want %h", rd, T_RESET_MTVEC); else n_pass++;
    endtask

    // Main sequence
    initial begin
        n_checks        = 0;
        n_pass          = 0;
        reset           = 1'b1;
        csr_address     = 12'h0;
        csr_command     = 3'd0;
        csr_write_data  = 64'h0;
        exception       = 1'b0;
        exception_cause = 5'd0;
        exception_pc    = 64'h0;
        exception_tval  = 64'h0;
        mret            = 1'b0;
        irq_software    = 1'b0;
        irq_timer       = 1'b0;
        irq_external    = 1'b0;
        interrupt_pc    = 64'h0;
        redirect_ready  = 1'b0;
        test_reset();
        test_csr_rmw();
        test_exception();
        test_interrupt_mret();
        test_vectored();
        test_back_to_back();
        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/m_trap_unit.md
# m_trap_unit

Machine-mode CSR file and trap sequencer for the Lagarto Hun core, replacing the single-mode CSR register block. It serves CSR instructions with read/write/set/clear semantics and captures exceptions and the three machine interrupts (software, timer, external). It executes `mret` and drives a PC-redirect handshake toward the fetch stage. It sits beside the execute stage and stalls the core via `busy_o` while a trap or `mret` is in flight.

## Interface
Parameters:
- `MXLEN`, 64: CSR width; 32 or 64.
- `XLEN`, 64: PC width.
- `HART_ID`, 0: value returned by `mhartid`.
- `RESET_MTVEC`, 0: reset value of `mtvec`; bits [1:0] must be 0.

Ports:
- `clock_i` in 1: the single clock; all state updates on its rising edge.
- `reset_i` in 1: reset is synchronous and active-high.
- `csr_address_i` in 12: CSR address.
- `csr_command_i` in 3: 0 NONE, 1 READ_ONLY, 2 WRITE_ONLY, 3 WRITE_AND_READ, 4 SET_AND_READ, 5 CLEAR_AND_READ; 6–7 behave as NONE.
- `csr_write_data_i` in MXLEN: write, set or clear operand.
- `csr_read_data_o` out MXLEN: old CSR value, combinational.
- `csr_read_data_valid_o` out 1: the access is legal and has been accepted.
- `csr_illegal_o` out 1: illegal CSR access; the core raises an illegal-instruction exception.
- `exception_i` in 1: synchronous exception request.
- `exception_cause_i` in 5: exception code.
- `exception_pc_i` in XLEN: PC of the faulting instruction.
- `exception_tval_i` in MXLEN: trap value.
- `mret_i` in 1: retire `mret`.
- `irq_software_i`, `irq_timer_i`, `irq_external_i` in 1 each: level-sensitive interrupt lines.
- `interrupt_pc_i` in XLEN: PC of the next instruction to retire; saved on interrupt.
- `busy_o` out 1: the unit is not in IDLE; the core holds its pipeline.
- `redirect_valid_o` out 1: `redirect_pc_o` is valid.
- `redirect_ready_i` in 1: fetch accepts the redirect.
- `redirect_pc_o` out XLEN: target PC.

## Operation
- Implemented CSRs:
  - `mstatus`: MIE bit 3, MPIE bit 7, MPP [12:11]. MPP always reads 2'b11. All other bits read 0.
  - `misa`: read-only. MXL is 1 for MXLEN=32 and 2 for MXLEN=64; extension bit 8 (I) is set.
  - `mie`: bits 3, 7, 11 writable; all other bits read 0.
  - `mtvec`, `mscratch`: writable.
  - `mepc`: bits [1:0] are forced to 0.
  - `mcause`: writable.
  - `mtval`: writable.
  - `mip`: bits 3, 7, 11 reflect the registered irq inputs; writes are ignored.
  - `mhartid`: read-only.
- Write value by command:
  - WRITE: the operand.
  - SET: old value OR operand.
  - CLEAR: old value AND NOT operand.
  - The result passes through the per-register write mask before it is stored.
- An access is illegal when any of the following holds:
  - the address is not implemented;
  - a write-class command (2–5) targets an address with [11:10]==2'b11;
  - a write-class command targets `misa`; these writes are rejected and flagged.
- For an illegal access: `csr_read_data_valid_o`=0, read data is 0, and no state changes.
- States:
  - IDLE: normal operation; the only state in which CSR commands are accepted.
  - REDIRECT: holds `redirect_valid_o`=1 and waits for `redirect_ready_i`.
- Events sampled in IDLE, highest priority first:
  1. `exception_i`.
  2. A pending enabled interrupt: `mstatus.MIE` & (`mip` & `mie`) != 0. Among interrupts, MEI beats MSI, which beats MTI.
  3. `mret_i`.
  4. The CSR command.
  - A lower-priority event arriving in the same cycle is dropped; for a CSR command this means `csr_read_data_valid_o`=0.
- Trap entry writes:
  - `mepc` = saved PC with [1:0]=0;
  - `mcause` = {interrupt bit at MXLEN-1, code};
  - `mtval` = `exception_tval_i` for an exception, 0 for an interrupt;
  - MPIE=MIE, then MIE=0.
  - The state then goes to REDIRECT.
- `mret` writes MIE=MPIE and MPIE=1, sets `redirect_pc_o`=`mepc`, and goes to REDIRECT.
- The trap target is {`mtvec`[XLEN-1:2], 2'b00}, subject to the Configuration option.
- In REDIRECT, `exception_i`, `mret_i`, interrupts and CSR commands are ignored.

## Timing
- Reset values:
  - all outputs are 0; state is IDLE;
  - `mtvec` = `RESET_MTVEC`;
  - MIE=0, MPIE=0;
  - all other CSRs are 0.
- CSR read data, `csr_read_data_valid_o` and `csr_illegal_o` are combinational in the same cycle. The CSR write commits at the next edge.
- Trap or `mret` sampled at edge T:
  - all CSR updates are visible from T;
  - `busy_o`=1 and `redirect_valid_o`=1 from T.
- While `redirect_valid_o`=1, `redirect_pc_o` stays stable.
- Handshake completes at the first edge where valid and ready are both 1. From that edge the state is IDLE and `busy_o`=0. Minimum trap occupancy is one cycle.
- irq inputs are registered once, so an interrupt can be taken 1 cycle after its line rises.
- Reset asserted in REDIRECT: IDLE and all outputs 0 at the next edge. The pending redirect is dropped.

## Configuration
- `LAGARTO_MTVEC_VECTORED_EN`: defined.
  - `mtvec`[1:0] accepts 0 (direct) and 1 (vectored); a write of 2 or 3 stores 0.
  - In vectored mode, the interrupt target is BASE + 4×code; exceptions always go to BASE.
- Not defined:
  - `mtvec`[1:0] is hardwired 0 and all traps go to BASE.

## Test plan
- Reset, then read `misa` at MXLEN=64 -> 0x8000_0000_0000_0100, valid=1; read `mtvec` -> `RESET_MTVEC`.
- Write `mscratch`=0xF0, then SET 0x0F, then CLEAR 0x30 -> reads 0xF0, then 0xFF, then 0xCF; a write to `mhartid` -> `csr_illegal_o`=1 and the value is unchanged.
- `mtvec`=0x1000, `exception_i` with cause 2, pc 0x2002, tval 0xDEAD -> next cycle:
  - `mepc`=0x2000, `mcause`=2, `mtval`=0xDEAD, MIE=0;
  - `redirect_pc_o`=0x1000, held 3 cycles with ready=0 and then accepted; `busy_o` drops on that same edge.
- Set MIE=1 and `mie`=0x888; raise timer and external together -> `mcause`=0x8000_0000_0000_000B, MPIE=1; after `mret` -> MIE=1 and `redirect_pc_o`=`mepc`.
- With the macro defined, `mtvec`=0x1001 and a timer interrupt -> target 0x101C; with the macro undefined -> target 0x1000 and `mtvec` reads 0x1000.
- `exception_i` and a CSR write in the same cycle -> the CSR write is dropped (valid=0) and the trap is taken; reset asserted mid-REDIRECT -> `redirect_valid_o`=0 at the next edge.
